// File: rtl/sb_cfg_pkg.sv
// rtl/sb_cfg_pkg.sv - shared types and frame geometry for the switch-box config loader
// Frame length depends on SB_CFG_PARITY_EN.
package sb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD,
    ST_COMMIT,
    ST_ERROR
  } sb_cfg_state_e;

  localparam int SB_CFG_W  = 6;
  localparam int SB_SYNC_W = 8;
  localparam int SB_DATA_BITS = 2 * SB_CFG_W;

`ifdef SB_CFG_PARITY_EN
  localparam int SB_FRAME_BITS = SB_DATA_BITS + 1;
`else
  localparam int SB_FRAME_BITS = SB_DATA_BITS;
`endif

  localparam int SB_BIT_CNT_W = $clog2(SB_FRAME_BITS);

endpackage

// File: rtl/sb_cfg_frame_shifter.sv
// rtl/sb_cfg_frame_shifter.sv - per-box frame shift register, bit counter and parity check
// Parity accumulator exists only when SB_CFG_PARITY_EN is defined.
module sb_cfg_frame_shifter
  import sb_cfg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    shift_i,
  input  logic                    bit_i,
  output logic [SB_DATA_BITS-1:0] frame_data_o,
  output logic                    frame_done_o,
  output logic                    parity_err_o
);

  logic [SB_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SB_DATA_BITS-1:0] shift_q, shift_d;
  logic                    last_bit;

  assign last_bit = (bit_cnt_q == SB_BIT_CNT_W'(SB_FRAME_BITS - 1));

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (clear_i) begin
      bit_cnt_d = '0;
    end else if (shift_i) begin
      // the parity bit (if any) is checked, never stored
      if (bit_cnt_q < SB_BIT_CNT_W'(SB_DATA_BITS)) begin
        shift_d = {shift_q[SB_DATA_BITS-2:0], bit_i};
      end
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // next-state view so the final data bit is visible on the completing edge
  assign frame_data_o = shift_d;
  assign frame_done_o = shift_i && last_bit;

`ifdef SB_CFG_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (clear_i) begin
      par_d = 1'b0;
    end else if (shift_i) begin
      par_d = last_bit ? 1'b0 : (par_q ^ bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity_err_o = frame_done_o && (par_q ^ bit_i);
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: rtl/sb_config_loader.sv
// rtl/sb_config_loader.sv - serial switch-box config loader with sync search and atomic commit
// Optional frame parity check under SB_CFG_PARITY_EN.
module sb_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int                   NUM_SB    = 4,
  parameter logic [SB_SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start_i,
  input  logic                       cfg_bit_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  output logic [SB_CFG_W*NUM_SB-1:0] dir_o,
  output logic [SB_CFG_W*NUM_SB-1:0] en_o,
  output logic                       busy_o,
  output logic                       cfg_done_o,
  output logic                       cfg_err_o
);

  localparam int OUT_W    = SB_CFG_W * NUM_SB;
  localparam int SB_CNT_W = (NUM_SB > 1) ? $clog2(NUM_SB) : 1;

  sb_cfg_state_e           state_q, state_d;
  logic [SB_SYNC_W-2:0]    window_q, window_d;
  logic [SB_SYNC_W-1:0]    win_full;
  logic [SB_CNT_W-1:0]     sb_cnt_q, sb_cnt_d;
  logic [OUT_W-1:0]        shadow_dir_q, shadow_dir_d;
  logic [OUT_W-1:0]        shadow_en_q, shadow_en_d;
  logic [OUT_W-1:0]        dir_q, dir_d;
  logic [OUT_W-1:0]        en_q, en_d;
  logic                    done_q, done_d;
  logic                    clear;
  logic                    shift;
  logic [SB_DATA_BITS-1:0] frame_data;
  logic                    frame_done;
  logic                    parity_err;

  assign cfg_ready_o = (state_q == ST_SYNC) || (state_q == ST_LOAD);
  assign busy_o      = cfg_ready_o || (state_q == ST_COMMIT);
  assign cfg_done_o  = done_q;
  assign dir_o       = dir_q;
  assign en_o        = en_q;
  assign shift       = cfg_valid_i && (state_q == ST_LOAD);
  // only the low seven bits of the window need storing; the eighth is the incoming bit
  assign win_full    = {window_q, cfg_bit_i};

`ifdef SB_CFG_PARITY_EN
  assign cfg_err_o = (state_q == ST_ERROR);
`else
  assign cfg_err_o = 1'b0;
`endif

  sb_cfg_frame_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear),
    .shift_i      (shift),
    .bit_i        (cfg_bit_i),
    .frame_data_o (frame_data),
    .frame_done_o (frame_done),
    .parity_err_o (parity_err)
  );

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    sb_cnt_d     = sb_cnt_q;
    shadow_dir_d = shadow_dir_q;
    shadow_en_d  = shadow_en_q;
    dir_d        = dir_q;
    en_d         = en_q;
    done_d       = 1'b0;
    clear        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (cfg_start_i) begin
          state_d  = ST_SYNC;
          window_d = '0;
          sb_cnt_d = '0;
          clear    = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cfg_valid_i) begin
          window_d = win_full[SB_SYNC_W-2:0];
          if (win_full == SYNC_WORD) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (frame_done) begin
          if (parity_err) begin
            state_d      = ST_ERROR;
            sb_cnt_d     = '0;
            shadow_dir_d = '0;
            shadow_en_d  = '0;
          end else begin
            for (int k = 0; k < NUM_SB; k++) begin
              if (sb_cnt_q == SB_CNT_W'(k)) begin
                shadow_dir_d[k*SB_CFG_W +: SB_CFG_W] = frame_data[SB_DATA_BITS-1:SB_CFG_W];
                shadow_en_d[k*SB_CFG_W +: SB_CFG_W]  = frame_data[SB_CFG_W-1:0];
              end
            end
            if (sb_cnt_q == SB_CNT_W'(NUM_SB - 1)) begin
              state_d  = ST_COMMIT;
              sb_cnt_d = '0;
            end else begin
              sb_cnt_d = sb_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_COMMIT: begin
        dir_d   = shadow_dir_q;
        en_d    = shadow_en_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      window_q     <= '0;
      sb_cnt_q     <= '0;
      shadow_dir_q <= '0;
      shadow_en_q  <= '0;
      dir_q        <= '0;
      en_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      sb_cnt_q     <= sb_cnt_d;
      shadow_dir_q <= shadow_dir_d;
      shadow_en_q  <= shadow_en_d;
      dir_q        <= dir_d;
      en_q         <= en_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// tb/tb_sb_config_loader.sv - randomized self-checking bench for sb_config_loader
// Parity scenarios run only when SB_CFG_PARITY_EN is defined.
module tb_sb_config_loader;

  localparam int NB = 4;
  localparam int W  = 6 * NB;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef SB_CFG_PARITY_EN
  localparam int FB = 13;
`else
  localparam int FB = 12;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start_i, cfg_bit_i, cfg_valid_i;
  logic         cfg_ready_o, busy_o, cfg_done_o, cfg_err_o;
  logic [W-1:0] dir_o, en_o;

  sb_config_loader #(.NUM_SB(NB), .SYNC_WORD(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start_i (cfg_start_i),
    .cfg_bit_i   (cfg_bit_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .dir_o       (dir_o),
    .en_o        (en_o),
    .busy_o      (busy_o),
    .cfg_done_o  (cfg_done_o),
    .cfg_err_o   (cfg_err_o)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  bit           stream[$];
  logic [W-1:0] exp_dir, exp_en;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // garbage prefix, sync word, then frames box0 first, each field MSB first
  task automatic build_stream(input int glen, input logic [15:0] gbits,
                              input logic [W-1:0] d, input logic [W-1:0] e, input int flip);
    stream.delete();
    for (int i = 0; i < glen; i++) stream.push_back(gbits[glen-1-i]);
    for (int i = 7; i >= 0; i--) stream.push_back(SYNC[i]);
    for (int b = 0; b < NB; b++) begin
      for (int j = 5; j >= 0; j--) stream.push_back(d[b*6+j]);
      for (int j = 5; j >= 0; j--) stream.push_back(e[b*6+j]);
      if (FB == 13) stream.push_back((^{d[b*6 +: 6], e[b*6 +: 6]}) ^ (b == flip));
    end
  endtask

  // reference: scan for the first sync match, then decode frames from the raw bit list
  task automatic model_parse(output int last_idx, output logic [W-1:0] md,
                             output logic [W-1:0] me, output bit merr);
    logic [7:0]  w;
    logic [11:0] f;
    int          p;
    w = '0; p = -1; md = '0; me = '0; merr = 1'b0; last_idx = -1;
    for (int i = 0; i < stream.size(); i++) begin
      w = {w[6:0], stream[i]};
      if (w == SYNC) begin
        p = i + 1;
        break;
      end
    end
    if (p < 0) return;
    for (int b = 0; b < NB; b++) begin
      f = '0;
      for (int j = 0; j < 12; j++) f = {f[10:0], stream[p + b*FB + j]};
      last_idx = p + b*FB + FB - 1;
      if (FB == 13 && ((^f) != stream[p + b*FB + 12])) begin
        merr = 1'b1;
        return;
      end
      md[b*6 +: 6] = f[11:6];
      me[b*6 +: 6] = f[5:0];
    end
  endtask

  task automatic pulse_start(input string tag);
    cfg_start_i = 1'b1;
    @(posedge clk); #1;
    cfg_start_i = 1'b0;
    check_eq({tag, "_busy_after_start"}, busy_o, 1);
    check_eq({tag, "_err_after_start"}, cfg_err_o, 0);
  endtask

  task automatic gap_cycle(input bit poke);
    cfg_valid_i = 1'b0;
    cfg_bit_i   = 1'($urandom);
    cfg_start_i = poke && ($urandom_range(3) == 0);
    @(posedge clk); #1;
    cfg_start_i = 1'b0;
  endtask

  // mode 0: valid held high, 1: valid every other cycle, 2: random gaps
  task automatic run_load(input string tag, input int mode, input bit poke);
    int           last;
    logic [W-1:0] md, me;
    bit           merr;
    model_parse(last, md, me, merr);
    pulse_start(tag);
    for (int i = 0; i <= last; i++) begin
      if (mode == 1) gap_cycle(poke);
      if (mode == 2) begin
        for (int g = 0; g < 5 && $urandom_range(99) < 30; g++) gap_cycle(poke);
      end
      cfg_valid_i = 1'b1;
      cfg_bit_i   = stream[i];
      check_eq({tag, "_ready"}, cfg_ready_o, 1);
      @(posedge clk); #1;
    end
    cfg_valid_i = 1'b0;
    check_eq({tag, "_ready_low"}, cfg_ready_o, 0);
    check_eq({tag, "_dir_held"}, dir_o, exp_dir);
    check_eq({tag, "_en_held"}, en_o, exp_en);
    check_eq({tag, "_done_early"}, cfg_done_o, 0);
    if (merr) begin
      check_eq({tag, "_err"}, cfg_err_o, 1);
      check_eq({tag, "_busy_err"}, busy_o, 0);
      @(posedge clk); #1;
      check_eq({tag, "_dir_kept"}, dir_o, exp_dir);
      check_eq({tag, "_no_done"}, cfg_done_o, 0);
    end else begin
      check_eq({tag, "_busy_commit"}, busy_o, 1);
      @(posedge clk); #1;
      check_eq({tag, "_dir"}, dir_o, md);
      check_eq({tag, "_en"}, en_o, me);
      check_eq({tag, "_done"}, cfg_done_o, 1);
      check_eq({tag, "_busy_idle"}, busy_o, 0);
      check_eq({tag, "_err_idle"}, cfg_err_o, 0);
      @(posedge clk); #1;
      check_eq({tag, "_done_pulse"}, cfg_done_o, 0);
      exp_dir = md;
      exp_en  = me;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rd, re;
    rst_n = 1'b0; cfg_start_i = 1'b0; cfg_bit_i = 1'b0; cfg_valid_i = 1'b0;
    exp_dir = '0; exp_en = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dir", dir_o, 0);
    check_eq("rst_en", en_o, 0);
    check_eq("rst_ready", cfg_ready_o, 0);
    check_eq("rst_done", cfg_done_o, 0);
    check_eq("rst_err", cfg_err_o, 0);
    check_eq("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    build_stream(0, 16'h0, '0, W'(24'h000010), -1);
    run_load("basic", 0, 0);
    check_eq("basic_en_box0", en_o, 24'h000010);

    build_stream(5, 16'($urandom), W'($urandom), W'($urandom), -1);
    run_load("rand_a", 2, 1);

    build_stream(0, 16'h0, '0, W'(24'h000010), -1);
    run_load("gapped", 1, 1);
    check_eq("gapped_en_box0", en_o, 24'h000010);

    rd = W'($urandom); rd[5:0] = 6'b101010;
    build_stream(3, 16'b101, rd, W'($urandom), -1);
    run_load("garbage", 0, 0);
    check_eq("garbage_dir_box0", dir_o[5:0], 6'b101010);

    for (int it = 0; it < 6; it++) begin
      build_stream($urandom_range(12), 16'($urandom), W'($urandom), W'($urandom), -1);
      run_load($sformatf("rand_%0d", it), it % 3, 1);
    end

`ifdef SB_CFG_PARITY_EN
    build_stream(0, 16'h0, W'($urandom), W'($urandom), 2);
    run_load("parity_bad", 0, 0);
    build_stream(2, 16'h2, W'($urandom), W'($urandom), -1);
    run_load("parity_recover", 2, 0);
`endif

    rd = W'($urandom) | W'(1);
    re = W'($urandom);
    build_stream(0, 16'h0, rd, re, -1);
    run_load("pre_reset", 0, 0);
    build_stream(0, 16'h0, W'($urandom), W'($urandom), -1);
    pulse_start("midload");
    for (int i = 0; i < 8 + 20; i++) begin
      cfg_valid_i = 1'b1;
      cfg_bit_i   = stream[i];
      @(posedge clk); #1;
    end
    cfg_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_dir", dir_o, 0);
    check_eq("async_rst_en", en_o, 0);
    check_eq("async_rst_ready", cfg_ready_o, 0);
    check_eq("async_rst_busy", busy_o, 0);
    check_eq("async_rst_done", cfg_done_o, 0);
    exp_dir = '0;
    exp_en  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    build_stream(4, 16'($urandom), W'($urandom), W'($urandom), -1);
    run_load("after_reset", 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sb_config_loader.md
# sb_config_loader

Serial configuration loader for the switch-box routing fabric. It accepts a configuration bitstream over a one-bit valid/ready link, finds a sync word, and assembles per-box frames into shadow registers. It then commits all `dir`/`en` words atomically to the `switch_box` instances it drives. It sits directly upstream of the `switch_box` array; its outputs connect straight to each box's `dir` and `en` inputs.

## Interface
Parameters:
- `NUM_SB`, default 4: number of switch boxes driven, minimum 1.
- `SYNC_WORD`, default 8'hA5: pattern that marks the start of the payload.

Ports:
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cfg_start_i` input 1: one-cycle pulse that begins a load; honoured only in IDLE or ERROR.
- `cfg_bit_i` input 1: serial configuration bit.
- `cfg_valid_i` input 1: `cfg_bit_i` is valid this cycle.
- `cfg_ready_o` output 1: loader can accept a bit. A bit transfers when valid and ready are both high.
- `dir_o` output 6*NUM_SB: direction words; box k uses bits [6k+5:6k].
- `en_o` output 6*NUM_SB: enable words; box k uses bits [6k+5:6k].
- `busy_o` output 1: high in SYNC, LOAD and COMMIT.
- `cfg_done_o` output 1: one-cycle pulse when a commit occurs.
- `cfg_err_o` output 1: level, high while in ERROR.

## Operation
- States: IDLE, SYNC, LOAD, COMMIT, ERROR.
- Transitions:
  - IDLE/ERROR → SYNC on `cfg_start_i`.
  - SYNC → LOAD when the 8-bit window equals `SYNC_WORD`.
  - LOAD → COMMIT after the last bit of frame NUM_SB-1.
  - COMMIT → IDLE unconditionally.
  - LOAD → ERROR on a parity failure (only when parity is compiled in).
- `cfg_ready_o` is 1 only in SYNC and LOAD.
- SYNC behaviour:
  - The 8-bit window is cleared on entry.
  - Each accepted bit shifts in at the LSB.
  - Unlimited garbage may precede the sync word.
- Frame layout, MSB first: `dir[5]`..`dir[0]`, then `en[5]`..`en[0]`. Box 0 is sent first.
- Counters:
  - `bit_cnt` counts 0..FRAME_BITS-1 and wraps to 0 at the end of each frame.
  - `sb_cnt` counts 0..NUM_SB-1. `sb_cnt` wraps to 0 on entering COMMIT.
- Completed frames are written to shadow registers only. `dir_o`/`en_o` keep the previous configuration until COMMIT, so the fabric never sees partial routing.
- `cfg_start_i` is ignored in SYNC, LOAD and COMMIT.
- When `cfg_valid_i` is low, no state, counter or window changes.
- Reset values: `dir_o`=0, `en_o`=0 (all switches off, lines high-Z), `cfg_ready_o`=0, `busy_o`=0, `cfg_done_o`=0, `cfg_err_o`=0, state=IDLE.
- Reset mid-load discards the shadow registers and counters and clears all outputs to their reset values.

## Timing
- Transfer rate: one bit per cycle at most; throughput is 1 when valid is held high.
- The sync match is evaluated on the accepting edge. The first payload bit can be accepted on the very next cycle.
- Commit latency:
  - The last payload bit is accepted at edge k, and the state enters COMMIT.
  - At edge k+1, `dir_o`/`en_o` update and `cfg_done_o` goes high for exactly the cycle following edge k+1.
  - The state is back in IDLE after edge k+1, so `cfg_ready_o` is low from edge k onward.
- Minimum load time after the start pulse: 8 + NUM_SB*FRAME_BITS + 1 cycles.

## Configuration
- Macro: `SB_CFG_PARITY_EN`.
- When defined:
  - FRAME_BITS = 13; the 13th bit is even parity over the 12 data bits.
  - The check happens on the edge that accepts the parity bit, with no extra cycle.
  - On mismatch: go to ERROR, drop the shadow registers, leave `dir_o`/`en_o` unchanged.
- When not defined: FRAME_BITS = 12 and ERROR is unreachable; `cfg_err_o` is tied to 0.

## Structure
- Package `sb_cfg_pkg` holds:
  - the state enum;
  - `SB_CFG_W` = 6;
  - `SB_SYNC_W` = 8;
  - `SB_FRAME_BITS`, selected by the macro.
- Sub-module `sb_cfg_frame_shifter`: frame shift register, `bit_cnt`, parity accumulator and `frame_done` strobe. The top level owns the FSM, the sync window, `sb_cnt`, the shadow registers and the output registers.

## Test plan
- Reset asserted → `dir_o`=0, `en_o`=0, `cfg_ready_o`=0, `cfg_done_o`=0, `cfg_err_o`=0.
- NUM_SB=4; start, 8'hA5, then box0 dir=6'b000000/en=6'b010000 and boxes 1–3 all zero, valid held high → one cycle after the last bit, `en_o`[5:0]=6'b010000, all other bits 0, `cfg_done_o` high for 1 cycle.
- Same stream with `cfg_valid_i` toggled every other cycle → identical final outputs; `bit_cnt` holds during gaps; commit delayed accordingly.
- Garbage 3'b101 before 8'hA5 → correct alignment; box0 `dir_o`=6'b101010 when sent as such.
- With `SB_CFG_PARITY_EN`, parity of frame 2 flipped → `cfg_err_o`=1, `cfg_ready_o`=0, outputs keep the prior config; a new start followed by a valid stream commits normally.
- `rst_n` pulled low after 20 payload bits → outputs and state return to reset values immediately (asynchronously); a new load succeeds afterwards.
